// File: rtl/usr_pkg.sv
// Shared types for the universal shift register and its frame controller.
//   sel_e   : register mode select (hold / shift right / shift left / load)
//   state_e : frame controller FSM states
package usr_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/usr_shift_register.sv
// Universal shift register driven by usr_frame_controller.
// Ports:
//   CLK       clock, rising edge
//   Clear_b   asynchronous active-low clear of the register contents
//   sel_line  mode: 00 hold, 01 shift right (toward bit 0),
//             10 shift left (toward bit WIDTH-1), 11 parallel load
//   par_in    parallel load data
//   msb_in    serial input entering bit WIDTH-1 on shift right
//   lsb_in    serial input entering bit 0 on shift left
//   q         register contents
module usr_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic [1:0]       sel_line,
  input  logic [WIDTH-1:0] par_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      q <= '0;
    end else begin
      case (sel_e'(sel_line))
        SEL_SHR:  q <= {msb_in, q[WIDTH-1:1]};
        SEL_SHL:  q <= {q[WIDTH-2:0], lsb_in};
        SEL_LOAD: q <= par_in;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_frame_controller.sv
// Frame controller for the universal shift register: accepts a word over a
// valid/ready handshake, loads it into the register, shifts it out one bit
// per cycle (LSB- or MSB-first) and streams the outgoing bit.
// Ports:
//   CLK, Clear_b          clock / asynchronous active-low reset
//   s_valid/s_ready       upstream handshake
//   s_data                word to serialize
//   s_msb_first           1 = MSB-first, 0 = LSB-first
//   s_fill                serial fill bit shifted in behind the word
//   sel_line              register mode select
//   par_out               register parallel input (captured word)
//   msb_in, lsb_in        register serial inputs (captured fill bit)
//   sr_q                  register parallel output, fed back
//   ser_out, ser_valid    outgoing serial bit and its qualifier
//   frame_done            one-cycle pulse after the last bit
//   busy                  frame in progress
module usr_frame_controller
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_msb_first,
  input  logic             s_fill,
  output logic [1:0]       sel_line,
  output logic [WIDTH-1:0] par_out,
  output logic             msb_in,
  output logic             lsb_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  sel_e             sel_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_q;
  logic             msb_first_q;
  logic             fill_q;

  // Only the end bits of sr_q are tapped; the rest is folded here.
  logic             unused_sr;
  assign unused_sr = ^sr_q;

  // Outputs are registered alongside the state so each one is a flop.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state       <= IDLE;
      sel_q       <= SEL_HOLD;
      cnt         <= '0;
      data_q      <= '0;
      msb_first_q <= 1'b0;
      fill_q      <= 1'b0;
      s_ready     <= 1'b1;
      ser_valid   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            data_q      <= s_data;
            msb_first_q <= s_msb_first;
            fill_q      <= s_fill;
            state       <= LOAD;
            sel_q       <= SEL_LOAD;
            s_ready     <= 1'b0;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state     <= SHIFT;
          cnt       <= '0;
          ser_valid <= 1'b1;
          sel_q     <= msb_first_q ? SEL_SHL : SEL_SHR;
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= DONE;
            sel_q      <= SEL_HOLD;
            ser_valid  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          s_ready    <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sel_line = sel_q;
  assign par_out  = data_q;
  assign msb_in   = fill_q;
  assign lsb_in   = fill_q;

  // The bit leaving the register is the one at the end it shifts away from.
  always_comb begin
    ser_out = 1'b0;
    if (state == SHIFT) begin
      ser_out = msb_first_q ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

endmodule

// File: tb/tb_usr_frame_controller.sv
// Bench for usr_frame_controller connected to usr_shift_register.
module tb_usr_frame_controller;
  import usr_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         clear_b;
  logic         reg_clear_b;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_msb_first;
  logic         s_fill;
  logic [1:0]   sel_line;
  logic [W-1:0] par_out;
  logic         msb_in;
  logic         lsb_in;
  logic [W-1:0] sr_q;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_done;
  logic         busy;

  int tests;
  int failed;
  int cyc;
  int accepts;
  int acc_cyc;
  int acc_cyc_prev;
  logic exp_q[$];

  usr_frame_controller #(.WIDTH(W)) dut (
    .CLK        (clk),
    .Clear_b    (clear_b),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_msb_first(s_msb_first),
    .s_fill     (s_fill),
    .sel_line   (sel_line),
    .par_out    (par_out),
    .msb_in     (msb_in),
    .lsb_in     (lsb_in),
    .sr_q       (sr_q),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  usr_shift_register #(.WIDTH(W)) sreg (
    .CLK     (clk),
    .Clear_b (reg_clear_b),
    .sel_line(sel_line),
    .par_in  (par_out),
    .msb_in  (msb_in),
    .lsb_in  (lsb_in),
    .q       (sr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note handshake, advance past the edge, score any serial bit.
  task automatic tick();
    logic acc;
    logic e;
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      accepts++;
      acc_cyc_prev = acc_cyc;
      acc_cyc      = cyc;
    end
    if (ser_valid) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        failed++;
        $error("FAIL ser_extra observed=%0d expected=0 unexpected bits", 1);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ser_out", 32'(ser_out), 32'(e));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},    32'(s_ready),    32'd1);
    check({tag, "_sel_line"},   32'(sel_line),   32'd0);
    check({tag, "_par_out"},    32'(par_out),    32'd0);
    check({tag, "_msb_in"},     32'(msb_in),     32'd0);
    check({tag, "_lsb_in"},     32'(lsb_in),     32'd0);
    check({tag, "_ser_out"},    32'(ser_out),    32'd0);
    check({tag, "_ser_valid"},  32'(ser_valid),  32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  // Full frame: present word, wait for accept, follow it to the end.
  // When keep_valid is set the next word is presented right after accept.
  task automatic run_frame(input logic [W-1:0] d, input logic msb, input logic fill,
                           input logic keep_valid, input logic [W-1:0] nd,
                           input logic nmsb, input logic nfill);
    int n;
    int acc_before;
    logic [W-1:0] fill_word;
    s_valid     = 1'b1;
    s_data      = d;
    s_msb_first = msb;
    s_fill      = fill;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(s_ready), 32'd1);
    for (int k = 0; k < W; k++) exp_q.push_back(msb ? d[W-1-k] : d[k]);
    acc_before = accepts;
    tick();
    if (keep_valid) begin
      s_data      = nd;
      s_msb_first = nmsb;
      s_fill      = nfill;
    end else begin
      s_valid = 1'b0;
    end
    check("accepted",      32'(accepts),  32'(acc_before + 1));
    check("load_sel",      32'(sel_line), 32'(SEL_LOAD));
    check("load_busy",     32'(busy),     32'd1);
    check("load_s_ready",  32'(s_ready),  32'd0);
    check("load_par_out",  32'(par_out),  32'(d));
    check("load_msb_in",   32'(msb_in),   32'(fill));
    check("load_lsb_in",   32'(lsb_in),   32'(fill));
    tick();
    check("shift_sel",     32'(sel_line),  msb ? 32'(SEL_SHL) : 32'(SEL_SHR));
    check("shift_valid",   32'(ser_valid), 32'd1);
    n = 0;
    while (!frame_done && n < W + 4) begin
      tick();
      n++;
    end
    fill_word = fill ? '1 : '0;
    check("done_pulse",    32'(frame_done), 32'd1);
    check("done_latency",  32'(n),          32'(W));
    check("done_sel",      32'(sel_line),   32'(SEL_HOLD));
    check("done_valid",    32'(ser_valid),  32'd0);
    check("done_busy",     32'(busy),       32'd1);
    check("busy_ignored",  32'(accepts),    32'(acc_before + 1));
    check("busy_par_out",  32'(par_out),    32'(d));
    check("reg_fill",      32'(sr_q),       32'(fill_word));
    check("bits_left",     32'(exp_q.size()), 32'd0);
    tick();
    check("idle_pulse_end", 32'(frame_done), 32'd0);
    check("idle_s_ready",   32'(s_ready),    32'd1);
    check("idle_busy",      32'(busy),       32'd0);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    cyc          = 0;
    accepts      = 0;
    acc_cyc      = 0;
    acc_cyc_prev = 0;
    clear_b      = 1'b0;
    reg_clear_b  = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    s_msb_first  = 1'b0;
    s_fill       = 1'b0;

    // Reset held, then released with no traffic.
    repeat (3) tick();
    check_reset_outputs("in_reset");
    @(negedge clk);
    clear_b     = 1'b1;
    reg_clear_b = 1'b1;
    repeat (3) tick();
    check_reset_outputs("after_reset");

    // LSB-first, fill 0.
    run_frame(4'b1011, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    // MSB-first, fill 1.
    run_frame(4'b1011, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // s_valid held: two words back to back.
    run_frame(4'b0110, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b0);
    run_frame(4'b1001, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("b2b_period", 32'(acc_cyc - acc_cyc_prev), 32'(W + 3));

    // Reset in the second SHIFT cycle discards the frame.
    s_valid     = 1'b1;
    s_data      = 4'b1010;
    s_msb_first = 1'b0;
    s_fill      = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check("mid_shift_valid", 32'(ser_valid), 32'd1);
    #2;
    clear_b = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    clear_b = 1'b1;
    tick();
    check("post_reset_ready", 32'(s_ready), 32'd1);
    check("post_reset_busy",  32'(busy),    32'd0);
    check("post_reset_queue", 32'(exp_q.size()), 32'd0);
    run_frame(4'b1100, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/usr_frame_controller.md
# usr_frame_controller

Upstream sequencer for the universal shift register. It accepts parallel words over a valid/ready handshake, drives the register's select, parallel-data and serial-fill inputs to load each word, then shifts it out one bit per cycle, LSB-first or MSB-first. It reads the register's parallel output back and presents the outgoing bit as a qualified serial stream with an end-of-frame pulse.

## Interface
Parameters:
- WIDTH, 4: register and word width; must be ≥ 2.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Clear_b  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream word available.
- s_ready  out  1  controller can accept a word.
- s_data  in  WIDTH  word to serialize.
- s_msb_first  in  1  direction for this word: 1 = MSB-first, 0 = LSB-first.
- s_fill  in  1  serial fill bit for this word.
- sel_line  out  2  register mode: 00 hold, 01 shift right (toward bit 0), 10 shift left (toward bit WIDTH-1), 11 parallel load.
- par_out  out  WIDTH  register parallel input.
- msb_in  out  1  register serial input used on shift right.
- lsb_in  out  1  register serial input used on shift left.
- sr_q  in  WIDTH  register parallel output, fed back.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out is valid this cycle.
- frame_done  out  1  one-cycle pulse after the last bit.
- busy  out  1  a frame is in progress.

## Operation
- FSM states and outputs:
  - IDLE: s_ready=1, sel_line=00.
  - LOAD: sel_line=11, par_out = captured data.
  - SHIFT: sel_line=10 if MSB-first, else 01; ser_valid=1; ser_out = sr_q[WIDTH-1] if MSB-first, else sr_q[0].
  - DONE: sel_line=00, frame_done=1.
- Transitions:
  - IDLE→LOAD when s_valid && s_ready. On that edge, s_data, s_msb_first and s_fill are captured into internal registers.
  - LOAD→SHIFT unconditionally.
  - SHIFT→DONE after WIDTH SHIFT cycles.
  - DONE→IDLE unconditionally.
- Bit counter: width $clog2(WIDTH+1). Cleared entering SHIFT, incremented each SHIFT cycle. The last SHIFT cycle is the one where the count equals WIDTH-1.
- msb_in and lsb_in both equal the captured fill bit in every state.
- par_out equals the captured data in every state. It is only sampled by the register in LOAD.
- After a frame the register holds all fill bits.
- busy=1 in LOAD, SHIFT and DONE.
- Handshake:
  - s_ready is low in LOAD, SHIFT and DONE. s_valid in those states is ignored.
  - Upstream must hold s_data, s_msb_first and s_fill stable until accepted.
  - No back-to-back acceptance: the earliest next accept is the first IDLE cycle.
- Reset, asynchronous and allowed mid-frame:
  - State returns to IDLE; counter and captured registers clear to 0.
  - Output values during and after reset: s_ready=1, sel_line=00, par_out=0, msb_in=0, lsb_in=0, ser_out=0, ser_valid=0, frame_done=0, busy=0.
  - A partially shifted frame is discarded. The register contents are not cleared by this block.

## Timing
- Handshake fires at edge E0.
- The LOAD cycle spans E0→E1; the register loads at E1.
- SHIFT cycles span E1→E(WIDTH+1). Bit k is on ser_out in the (k+1)-th SHIFT cycle and is taken from sr_q, which is valid because the load occurred at E1.
- DONE spans E(WIDTH+1)→E(WIDTH+2). s_ready is high again from E(WIDTH+2).
- Frame period: WIDTH+3 cycles for back-to-back words.
- All outputs are decoded from registered state and captured registers only. ser_out is combinational from sr_q and state. There is no combinational path from s_valid to any output except through state.

## Structure
- Package usr_pkg:
  - typedef enum logic [1:0] sel_e with values SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
  - typedef enum state_e with values IDLE, LOAD, SHIFT, DONE.
  - The shift register uses the same sel_e.
- No sub-module: FSM, counter and capture registers live in one module.
- The bench instantiates this block plus the universal shift register, with sel_line/par_out/msb_in/lsb_in→register and register out→sr_q.

## Test plan
- Reset held, then released with s_valid=0 → all outputs at their reset values; s_ready=1; sel_line stays 00.
- s_data=1011, s_msb_first=0, s_fill=0 → LOAD with sel_line=11; ser_out = 1,1,0,1 on four ser_valid cycles; sel_line=01; frame_done one cycle later; register ends at 0000.
- s_data=1011, s_msb_first=1, s_fill=1 → sel_line=10; ser_out = 1,0,1,1; register ends at 1111; frame_done pulse.
- s_valid held high with words 0110 (LSB-first) then 1001 (MSB-first) → second accept exactly 7 cycles after the first; streams are 0,1,1,0 then 1,0,0,1; s_valid during busy is not accepted.
- Clear_b pulsed low during the 2nd SHIFT cycle → outputs immediately at reset values; after release the controller is in IDLE and a new word 1100 serializes correctly (LSB-first: 0,0,1,1).
